// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg: shared state encoding, default parameters and clog2 helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bist_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM_AUTO = 3'd1,
        RST      = 3'd2,
        START    = 3'd3,
        WAIT_END = 3'd4,
        EVAL     = 3'd5,
        REPORT   = 3'd6
    } state_e;

    localparam int unsigned MISR_BITS_DEF       = 8;
    localparam logic [7:0]  SIGNATURE_VALID_DEF = 8'hF9;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bist_watchdog.sv
// ---------------------------------------------------------------------------
// bist_watchdog: loadable down-counter with clear/enable; expired at zero.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bist_watchdog #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Decrement stops at zero so the counter can never wrap.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/bist_session_manager.sv
// ---------------------------------------------------------------------------
// bist_session_manager: launches, watches and retries BIST sessions on the top.
// Optional BIST_LOCAL_CHECK_EN: verdict from local signature compare. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bist_session_manager
    import bist_pkg::*;
#(
    parameter int unsigned          MISR_BITS       = MISR_BITS_DEF,
    parameter logic [MISR_BITS-1:0] SIGNATURE_VALID = SIGNATURE_VALID_DEF,
    parameter int unsigned          TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int unsigned          MAX_RETRIES     = 2,
    parameter int unsigned          RST_CYCLES      = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 run_req_i,
    input  logic                 auto_start_i,
    input  logic                 bist_end_i,
    input  logic                 pass_fail_i,
    input  logic [MISR_BITS-1:0] signature_in_i,
    output logic                 dut_reset_o,
    output logic                 bist_start_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 result_pass_o,
    output logic                 timeout_err_o,
    output logic [1:0]           attempts_o,
    output logic [MISR_BITS-1:0] sig_captured_o
);

    localparam int unsigned TO_W = clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned RS_W = clog2(RST_CYCLES) + 1;
    localparam int unsigned WD_W = (TO_W > RS_W) ? TO_W : RS_W;
    localparam logic [WD_W-1:0] C_WD_TIMEOUT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] C_WD_RST     = WD_W'(RST_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 first_edge_q, hold_q, hold_d;
    logic [1:0]           attempts_q, attempts_d;
    logic                 armed_q, armed_d;
    logic                 verdict_q, verdict_d;
    logic                 tout_q, tout_d;
    logic [MISR_BITS-1:0] sig_q, sig_d;
    logic                 result_pass_q, result_pass_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [MISR_BITS-1:0] sig_captured_q, sig_captured_d;

    logic            wd_clr, wd_load, wd_en, wd_expired, go_report, verdict_now;
    logic [WD_W-1:0] wd_val;

`ifdef BIST_LOCAL_CHECK_EN
    assign verdict_now = (signature_in_i == SIGNATURE_VALID);
    logic unused_pass_fail;
    assign unused_pass_fail = pass_fail_i;
`else
    assign verdict_now = pass_fail_i;
    logic unused_sig_valid;
    assign unused_sig_valid = ^SIGNATURE_VALID;
`endif

    bist_watchdog #(
        .WIDTH (WD_W)
    ) u_watchdog (
        .clk_i      (clock_i),
        .rst_ni     (reset_ni),
        .clr_i      (wd_clr),
        .load_i     (wd_load),
        .load_val_i (wd_val),
        .en_i       (wd_en),
        .expired_o  (wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        attempts_d     = attempts_q;
        armed_d        = armed_q;
        verdict_d      = verdict_q;
        tout_d         = tout_q;
        sig_d          = sig_q;
        result_pass_d  = result_pass_q;
        timeout_err_d  = timeout_err_q;
        sig_captured_d = sig_captured_q;
        wd_clr         = 1'b0;
        wd_load        = 1'b0;
        wd_en          = 1'b0;
        wd_val         = C_WD_RST;
        go_report      = 1'b0;

        case (state_q)
            IDLE: begin
                wd_clr = 1'b1;
                if (first_edge_q && auto_start_i) begin
                    state_d = ARM_AUTO;
                end else if (run_req_i) begin
                    state_d       = RST;
                    wd_load       = 1'b1;
                    attempts_d    = 2'd0;
                    result_pass_d = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ARM_AUTO: begin
                state_d       = RST;
                wd_load       = 1'b1;
                attempts_d    = 2'd0;
                result_pass_d = 1'b0;
                timeout_err_d = 1'b0;
            end
            RST: begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    state_d = START;
                    hold_d  = 1'b0;
                    if (attempts_q != 2'd3) begin
                        attempts_d = attempts_q + 2'd1;
                    end
                end
            end
            START: begin
                state_d   = WAIT_END;
                wd_load   = 1'b1;
                wd_val    = C_WD_TIMEOUT;
                armed_d   = ~bist_end_i;
                verdict_d = 1'b0;
                tout_d    = 1'b0;
                sig_d     = '0;
            end
            WAIT_END: begin
                wd_en = 1'b1;
                if (!bist_end_i) begin
                    armed_d = 1'b1;
                end
                // A completion on the last counted cycle beats the timeout.
                if (bist_end_i && armed_q) begin
                    state_d   = EVAL;
                    verdict_d = verdict_now;
                    sig_d     = signature_in_i;
                end else if (wd_expired) begin
                    state_d = EVAL;
                    tout_d  = 1'b1;
                end
            end
            EVAL: begin
                if (verdict_q && !tout_q) begin
                    go_report = 1'b1;
                end else if (32'(attempts_q) <= MAX_RETRIES) begin
                    state_d = RST;
                    wd_load = 1'b1;
                end else begin
                    go_report = 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_report) begin
            state_d        = REPORT;
            result_pass_d  = verdict_q && !tout_q;
            timeout_err_d  = tout_q;
            sig_captured_d = sig_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= IDLE;
            first_edge_q   <= 1'b1;
            hold_q         <= 1'b1;
            attempts_q     <= 2'd0;
            armed_q        <= 1'b0;
            verdict_q      <= 1'b0;
            tout_q         <= 1'b0;
            sig_q          <= '0;
            result_pass_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
            sig_captured_q <= '0;
        end else begin
            state_q        <= state_d;
            first_edge_q   <= 1'b0;
            hold_q         <= hold_d;
            attempts_q     <= attempts_d;
            armed_q        <= armed_d;
            verdict_q      <= verdict_d;
            tout_q         <= tout_d;
            sig_q          <= sig_d;
            result_pass_q  <= result_pass_d;
            timeout_err_q  <= timeout_err_d;
            sig_captured_q <= sig_captured_d;
        end
    end

    assign dut_reset_o    = hold_q || (state_q == RST);
    assign bist_start_o   = (state_q == START) || (state_q == WAIT_END);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == REPORT);
    assign result_pass_o  = result_pass_q;
    assign timeout_err_o  = timeout_err_q;
    assign attempts_o     = attempts_q;
    assign sig_captured_o = sig_captured_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_session_manager.sv
// ---------------------------------------------------------------------------
// tb_bist_session_manager: directed sessions against a behavioural top model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bist_session_manager;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_req;
    logic       auto_start;
    logic       bist_end  = 1'b0;
    logic       pass_fail = 1'b0;
    logic [7:0] signature = 8'h00;

    logic       dut_reset, bist_start, busy, done, result_pass, timeout_err;
    logic [1:0] attempts;
    logic [7:0] sig_captured;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Top model configuration
    int unsigned m_delay     = 20;
    int unsigned m_fail_left = 0;
    int unsigned m_cnt       = 0;
    logic        m_pf        = 1'b1;
    logic [7:0]  m_sig       = 8'hF9;

    // Monitor counters
    int unsigned rst_len = 0, pulses = 0, rst_bad = 0;
    int unsigned bs_len = 0, last_bs = 0, done_cnt = 0;
    int unsigned p0, b0, d0;
    logic        exp_pass;
    logic [1:0]  exp_att;

    always #5 clk = ~clk;

    bist_session_manager dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .run_req_i      (run_req),
        .auto_start_i   (auto_start),
        .bist_end_i     (bist_end),
        .pass_fail_i    (pass_fail),
        .signature_in_i (signature),
        .dut_reset_o    (dut_reset),
        .bist_start_o   (bist_start),
        .busy_o         (busy),
        .done_o         (done),
        .result_pass_o  (result_pass),
        .timeout_err_o  (timeout_err),
        .attempts_o     (attempts),
        .sig_captured_o (sig_captured)
    );

    // Top model: bist_end rises after m_delay cycles of bist_start, cleared by dut_reset.
    always @(negedge clk) begin
        if (dut_reset) begin
            m_cnt    = 0;
            bist_end = 1'b0;
        end else if (bist_start && !bist_end) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == m_delay) begin
                bist_end = 1'b1;
                if (m_fail_left > 0) begin
                    pass_fail   = 1'b0;
                    signature   = 8'h3C;
                    m_fail_left = m_fail_left - 1;
                end else begin
                    pass_fail = m_pf;
                    signature = m_sig;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (dut_reset) begin
            rst_len = rst_len + 1;
        end else if (rst_len != 0) begin
            pulses = pulses + 1;
            if (rst_len != 2) rst_bad = rst_bad + 1;
            rst_len = 0;
        end
        if (bist_start) begin
            bs_len = bs_len + 1;
        end else if (bs_len != 0) begin
            last_bs = bs_len;
            bs_len  = 0;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned bound);
        int unsigned n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_report(input string tag, input logic pass, input logic tout,
                                input logic [1:0] att, input logic [7:0] sig);
        check({tag, "_pass"}, 32'(result_pass), 32'(pass));
        check({tag, "_timeout"}, 32'(timeout_err), 32'(tout));
        check({tag, "_attempts"}, 32'(attempts), 32'(att));
        check({tag, "_sig"}, 32'(sig_captured), 32'(sig));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n      = 1'b0;
        run_req    = 1'b0;
        auto_start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dut_reset", 32'(dut_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bist_start", 32'(bist_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_report("rst", 1'b0, 1'b0, 2'd0, 8'h00);

        // Auto-start session, single passing attempt
        rst_n = 1'b1;
        @(negedge clk);
        check("auto_busy", 32'(busy), 32'd1);
        auto_start = 1'b0;
        wait_done("auto_done", 300);
        check_report("auto", 1'b1, 1'b0, 2'd1, 8'hF9);
        @(negedge clk);
        check("auto_done_1cyc", 32'(done), 32'd0);
        check("idle_dut_reset", 32'(dut_reset), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Two failures then a pass
        m_fail_left = 2;
        #1;
        p0 = pulses; b0 = rst_bad; d0 = done_cnt;
        pulse_run();
        wait_done("retry_done", 600);
        check_report("retry", 1'b1, 1'b0, 2'd3, 8'hF9);
        @(negedge clk); #1;
        check("retry_rst_pulses", pulses - p0, 32'd3);
        check("retry_rst_width_bad", rst_bad - b0, 32'd0);
        check("retry_done_count", done_cnt - d0, 32'd1);

        // bist_end never arrives
        m_delay = 1000;
        p0 = pulses;
        pulse_run();
        wait_done("to_done", 800);
        check_report("to", 1'b0, 1'b1, 2'd3, 8'h00);
        #1;
        check("to_start_len", last_bs, 32'd65);
        check("to_rst_pulses", pulses - p0, 32'd3);

        // bist_end on the last WAIT_END cycle wins over the timeout
        m_delay = 65;
        pulse_run();
        wait_done("edge63_done", 300);
        check_report("edge63", 1'b1, 1'b0, 2'd1, 8'hF9);

        // One cycle later is a timeout
        m_delay = 66;
        pulse_run();
        wait_done("edge64_done", 800);
        check_report("edge64", 1'b0, 1'b1, 2'd3, 8'h00);

        // run_req while busy is ignored
        m_delay = 20;
        @(negedge clk); #1;
        d0 = done_cnt;
        pulse_run();
        repeat (10) @(negedge clk);
        check("ign_in_wait", 32'(bist_start), 32'd1);
        pulse_run();
        wait_done("ign_done", 300);
        check_report("ign", 1'b1, 1'b0, 2'd1, 8'hF9);
        repeat (5) @(negedge clk); #1;
        check("ign_busy_after", 32'(busy), 32'd0);
        check("ign_done_count", done_cnt - d0, 32'd1);

        // Asynchronous reset in the middle of WAIT_END
        m_delay = 40;
        pulse_run();
        repeat (15) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        #1;
        d0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("mid_dut_reset", 32'(dut_reset), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_bist_start", 32'(bist_start), 32'd0);
        check_report("mid", 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (50) @(negedge clk); #1;
        check("mid_no_done", done_cnt - d0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
        check("post_dut_reset", 32'(dut_reset), 32'd1);

        // Golden signature with pass_fail low
        m_delay = 20; m_pf = 1'b0; m_sig = 8'hF9;
`ifdef BIST_LOCAL_CHECK_EN
        exp_pass = 1'b1; exp_att = 2'd1;
`else
        exp_pass = 1'b0; exp_att = 2'd3;
`endif
        pulse_run();
        wait_done("gold_done", 600);
        check_report("gold", exp_pass, 1'b0, exp_att, 8'hF9);

        // Bad signature with pass_fail high
        m_pf = 1'b1; m_sig = 8'h3C;
`ifdef BIST_LOCAL_CHECK_EN
        exp_pass = 1'b0; exp_att = 2'd3;
`else
        exp_pass = 1'b1; exp_att = 2'd1;
`endif
        pulse_run();
        wait_done("bad_done", 600);
        check_report("bad", exp_pass, 1'b0, exp_att, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
